// File: rtl/instruction_fetch.sv
// Sequential fetch unit: owns the program counter, reads a combinational program
// memory and hands instructions to the decoder over a valid/ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | no instruction held; load the word at pc on the next edge
// HOLD    | instr/instr_pc valid, waiting for the decoder to take it
// HALTED  | everything frozen until reset
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  pm_addr,
    input  logic [INSTR_WIDTH-1:0] pm_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   jump_en,
    input  logic [ADDR_WIDTH-1:0]  jump_addr,
    input  logic                   halt,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;
    logic                   load;

    // A new word is loaded from FETCH, or from HOLD once the current one is taken.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        load          = 1'b0;

        case (state_q)
            S_FETCH, S_HOLD: begin
                if (halt) begin
                    state_d       = S_HALTED;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (jump_en) begin
                    state_d       = S_FETCH;
                    instr_valid_d = 1'b0;
                    pc_d          = jump_addr;
                end else if (state_q == S_FETCH || instr_ready) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (load) begin
            state_d       = S_HOLD;
            instr_d       = pm_data;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 1'b1;
            instr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign pm_addr     = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, directed corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pm_addr;
    logic [7:0] pm_data;
    logic [7:0] instr;
    logic [4:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [4:0] jump_addr;
    logic       halt;
    logic [4:0] pc;
    logic       halted;

    logic [7:0] image [32];
    int tests = 0;
    int fails = 0;

    // reference model: just the architectural view (pc, held instruction, flags)
    int m_pc, m_ipc, m_instr, m_valid, m_halted;

    instruction_fetch #(.ADDR_WIDTH(5), .INSTR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .pm_addr(pm_addr), .pm_data(pm_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
        .halt(halt), .pc(pc), .halted(halted)
    );

    assign pm_data = image[pm_addr];

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       jmp;
        logic [4:0] ja;
        logic       hlt;
        logic       v;
        logic [4:0] ipc;
        logic [4:0] epc;
        logic [7:0] ins;
        logic       h;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted == 0) begin
            if (halt) begin
                m_halted = 1;
                m_valid  = 0;
            end else if (jump_en) begin
                m_valid = 0;
                m_pc    = int'(jump_addr);
            end else if (m_valid == 0 || instr_ready) begin
                m_instr = int'(image[m_pc]);
                m_ipc   = m_pc;
                m_pc    = (m_pc + 1) % 32;
                m_valid = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("model.pc", int'(pc), m_pc);
        chk("model.pm_addr", int'(pm_addr), m_pc);
        chk("model.valid", int'(instr_valid), m_valid);
        chk("model.halted", int'(halted), m_halted);
        chk("model.instr", int'(instr), m_instr);
        chk("model.instr_pc", int'(instr_pc), m_ipc);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        reset = 1'b0; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = 5'd0; halt = 1'b0;
    endtask

    task automatic run_until_ipc(input int target, input string name);
        int n = 0;
        while (int'(instr_pc) != target && n < 40) begin
            tick();
            n++;
        end
        chk(name, int'(instr_pc), target);
    endtask

    initial begin
        image = '{8'h10, 8'h21, 8'h32, 8'h03, 8'h54, 8'h65, 8'h76, 8'h87,
                  8'h43, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                  8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
                  8'h89, 8'h9A, 8'hAB, 8'h00, 8'hBC, 8'hCD, 8'hDE, 8'h00};
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0;

        //          rst  rdy  jmp  ja     hlt  v    ipc    pc     instr  h
        vecs[0] = '{1'b1,1'b1,1'b0,5'd0, 1'b0,1'b0,5'd0, 5'd0, 8'h00,1'b0};
        vecs[1] = '{1'b0,1'b1,1'b0,5'd0, 1'b0,1'b1,5'd0, 5'd1, 8'h10,1'b0};
        vecs[2] = '{1'b0,1'b1,1'b0,5'd0, 1'b0,1'b1,5'd1, 5'd2, 8'h21,1'b0};
        vecs[3] = '{1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,5'd1, 5'd2, 8'h21,1'b0};
        vecs[4] = '{1'b0,1'b0,1'b1,5'd20,1'b0,1'b0,5'd1, 5'd20,8'h21,1'b0};
        vecs[5] = '{1'b0,1'b0,1'b0,5'd0, 1'b0,1'b1,5'd20,5'd21,8'h45,1'b0};
        vecs[6] = '{1'b0,1'b1,1'b0,5'd0, 1'b0,1'b1,5'd21,5'd22,8'h56,1'b0};
        vecs[7] = '{1'b0,1'b1,1'b0,5'd0, 1'b1,1'b0,5'd21,5'd22,8'h56,1'b1};
        vecs[8] = '{1'b0,1'b1,1'b1,5'd3, 1'b0,1'b0,5'd21,5'd22,8'h56,1'b1};
        vecs[9] = '{1'b1,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0, 5'd0, 8'h00,1'b0};

        idle_inputs();
        #2;
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; instr_ready = vecs[i].rdy; jump_en = vecs[i].jmp;
            jump_addr = vecs[i].ja; halt = vecs[i].hlt;
            tick();
            chk($sformatf("vec%0d.valid", i), int'(instr_valid), int'(vecs[i].v));
            chk($sformatf("vec%0d.instr_pc", i), int'(instr_pc), int'(vecs[i].ipc));
            chk($sformatf("vec%0d.pc", i), int'(pc), int'(vecs[i].epc));
            chk($sformatf("vec%0d.instr", i), int'(instr), int'(vecs[i].ins));
            chk($sformatf("vec%0d.halted", i), int'(halted), int'(vecs[i].h));
        end

        // first instruction latency and sequential issue
        idle_inputs(); reset = 1'b1; tick();
        reset = 1'b0; tick();
        chk("first.instr", int'(instr), 'h10);
        chk("first.instr_pc", int'(instr_pc), 0);
        chk("first.valid", int'(instr_valid), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("seq.instr_pc%0d", k), int'(instr_pc), k);
        end

        // backpressure at instr_pc 8
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall.instr", int'(instr), 'h43);
            chk("stall.pc", int'(pc), 9);
            chk("stall.instr_pc", int'(instr_pc), 8);
        end
        instr_ready = 1'b1; tick();
        chk("stall.release", int'(instr_pc), 9);

        // wrap-around
        run_until_ipc(31, "wrap.reach31");
        chk("wrap.instr31", int'(instr), 'h00);
        tick();
        chk("wrap.instr_pc", int'(instr_pc), 0);
        chk("wrap.instr", int'(instr), 'h10);
        chk("wrap.pc", int'(pc), 1);

        // jump during stalled HOLD discards instruction 3
        run_until_ipc(3, "jump.reach3");
        instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 5'd8; tick();
        chk("jump.bubble", int'(instr_valid), 0);
        jump_en = 1'b0; jump_addr = 5'd0; tick();
        chk("jump.valid", int'(instr_valid), 1);
        chk("jump.instr", int'(instr), 'h43);
        chk("jump.instr_pc", int'(instr_pc), 8);

        // halt wins over jump; state frozen afterwards
        idle_inputs(); reset = 1'b1; tick();
        reset = 1'b0;
        run_until_ipc(4, "halt.reach");
        chk("halt.pc_pre", int'(pc), 5);
        halt = 1'b1; jump_en = 1'b1; jump_addr = 5'd17; tick();
        for (int k = 0; k < 10; k++) begin
            chk("halt.halted", int'(halted), 1);
            chk("halt.valid", int'(instr_valid), 0);
            chk("halt.pc", int'(pc), 5);
            chk("halt.instr", int'(instr), 'h54);
            halt = 1'($urandom); jump_en = 1'($urandom); jump_addr = 5'($urandom);
            instr_ready = 1'($urandom);
            tick();
        end

        // reset while halted
        idle_inputs(); reset = 1'b1; tick();
        chk("rst_halt.halted", int'(halted), 0);
        chk("rst_halt.pc", int'(pc), 0);
        chk("rst_halt.valid", int'(instr_valid), 0);
        chk("rst_halt.instr", int'(instr), 0);
        reset = 1'b0; tick();
        chk("rst_halt.first", int'(instr), 'h10);

        // reset during HOLD at instr_pc 12
        run_until_ipc(12, "rst_hold.reach");
        instr_ready = 1'b0; reset = 1'b1; tick();
        chk("rst_hold.valid", int'(instr_valid), 0);
        chk("rst_hold.pc", int'(pc), 0);
        chk("rst_hold.instr_pc", int'(instr_pc), 0);
        chk("rst_hold.instr", int'(instr), 0);
        reset = 1'b0; tick();
        chk("rst_hold.first", int'(instr), 'h10);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(99) < 2);
            halt        = ($urandom_range(99) < 2);
            jump_en     = ($urandom_range(99) < 10);
            jump_addr   = 5'($urandom);
            instr_ready = ($urandom_range(99) < 70);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
